// File: rtl/usb_tx_encoder.sv
`default_nettype none
// ============================================================================
// Module   : usb_tx_encoder
// Purpose  : USB full-speed transmit packet encoder. Drains payload bytes
//            from an 8-bit show-ahead FIFO and emits SYNC, PID, payload,
//            optional CRC16 and EOP. The bit stream is bit-stuffed and
//            NRZI-encoded onto D+/D-.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            tx_start, tx_pid  - packet request and PID (sampled in IDLE)
//            r_data, empty     - FIFO head byte and empty flag
//            r_enable          - one-clock FIFO pop strobe
//            tx_busy, tx_done  - packet in flight / end-of-packet pulse
//            d_plus, d_minus   - line outputs (J = 1,0  K = 0,1)
// Options  : define USB_TX_CRC16_EN to append CRC16 to data-class packets.
// Revision : 1.0 - initial release
// ============================================================================
module usb_tx_encoder #(
    parameter int CLKS_PER_BIT = 4,
    parameter int MAX_BYTES    = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [3:0] tx_pid,
    input  logic [7:0] r_data,
    input  logic       empty,
    output logic       r_enable,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       d_plus,
    output logic       d_minus
);

    localparam int c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam int c_BC_W = $clog2(MAX_BYTES + 1);
    localparam logic [c_BC_W-1:0] c_MAX_BYTES = c_BC_W'(MAX_BYTES);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_SYNC    = 3'd1;
    localparam logic [2:0] c_ST_PID     = 3'd2;
    localparam logic [2:0] c_ST_DATA    = 3'd3;
`ifdef USB_TX_CRC16_EN
    localparam logic [2:0] c_ST_CRC     = 3'd4;
`endif
    localparam logic [2:0] c_ST_EOP_SE0 = 3'd5;
    localparam logic [2:0] c_ST_EOP_J   = 3'd6;

    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_clk_cnt;
    // Remaining bits of the current field; bit 0 of a field goes straight
    // to the line when the field is loaded, so only bits 7:1 are kept.
    logic [6:0]         r_shift;
    logic [2:0]         r_bit_idx;
    logic [2:0]         r_ones;
    logic [c_BC_W-1:0]  r_byte_cnt;
    logic [3:0]         r_pid;
    logic               r_dp;
    logic               r_dm;
    logic               r_pop;
    logic               r_busy;
    logic               r_done;
`ifdef USB_TX_CRC16_EN
    logic [15:0]        r_crc;
    logic               r_crc_hi;
    logic               w_ncrc_hi;

    // Reflected CRC-16 (poly 0x8005, LSB-first data) advanced by one byte.
    function automatic logic [15:0] f_crc16_byte(input logic [15:0] crc,
                                                 input logic [7:0]  data);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ 16'hA001;
            else                c = c >> 1;
        end
        return c;
    endfunction
`endif

    logic       w_bit_end;
    logic       w_stuff;
    logic       w_has_byte;
    logic [2:0] w_nstate;
    logic [7:0] w_nshift;
    logic [2:0] w_nidx;
    logic       w_npop;
    logic       w_nbit;

    assign w_bit_end  = (r_clk_cnt == c_CNT_LAST);
    // Only PID/DATA/CRC bits advance the run counter, so SYNC never stuffs.
    assign w_stuff    = (r_ones == 3'd6);
    assign w_has_byte = !empty && (r_byte_cnt < c_MAX_BYTES);
    assign w_nbit     = w_nshift[0];

    // Next bit to send when the current bit time ends and no stuff is owed.
    always_comb begin
        w_nstate = r_state;
        w_nshift = {1'b0, r_shift};
        w_nidx   = r_bit_idx + 3'd1;
        w_npop   = 1'b0;
`ifdef USB_TX_CRC16_EN
        w_ncrc_hi = r_crc_hi;
`endif
        if (r_bit_idx == 3'd7) begin
            w_nidx = 3'd0;
            case (r_state)
                c_ST_SYNC: begin
                    w_nstate = c_ST_PID;
                    w_nshift = {~r_pid, r_pid};
                end
                c_ST_PID, c_ST_DATA: begin
                    if (r_state == c_ST_PID && r_pid[1:0] != 2'b11) begin
                        w_nstate = c_ST_EOP_SE0;
                    end else if (w_has_byte) begin
                        w_nstate = c_ST_DATA;
                        w_nshift = r_data;
                        w_npop   = 1'b1;
                    end else begin
`ifdef USB_TX_CRC16_EN
                        w_nstate  = c_ST_CRC;
                        w_nshift  = ~r_crc[7:0];
                        w_ncrc_hi = 1'b0;
`else
                        w_nstate = c_ST_EOP_SE0;
`endif
                    end
                end
`ifdef USB_TX_CRC16_EN
                c_ST_CRC: begin
                    if (!r_crc_hi) begin
                        w_nshift  = ~r_crc[15:8];
                        w_ncrc_hi = 1'b1;
                    end else begin
                        w_nstate = c_ST_EOP_SE0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_clk_cnt  <= '0;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_ones     <= '0;
            r_byte_cnt <= '0;
            r_pid      <= '0;
            r_dp       <= 1'b1;
            r_dm       <= 1'b0;
            r_pop      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef USB_TX_CRC16_EN
            r_crc      <= 16'hFFFF;
            r_crc_hi   <= 1'b0;
`endif
        end else begin
            r_pop  <= 1'b0;
            r_done <= 1'b0;
            if (r_state != c_ST_IDLE)
                r_clk_cnt <= w_bit_end ? '0 : r_clk_cnt + 1'b1;

            case (r_state)
                c_ST_IDLE: begin
                    if (tx_start) begin
                        r_pid      <= tx_pid;
                        r_state    <= c_ST_SYNC;
                        // SYNC is 0x80: bit 0 (a 0) goes out now as K.
                        r_shift    <= 7'h40;
                        r_bit_idx  <= 3'd0;
                        r_ones     <= 3'd0;
                        r_byte_cnt <= '0;
                        r_clk_cnt  <= '0;
                        r_dp       <= 1'b0;
                        r_dm       <= 1'b1;
                        r_busy     <= 1'b1;
`ifdef USB_TX_CRC16_EN
                        r_crc      <= 16'hFFFF;
`endif
                    end
                end
                c_ST_EOP_SE0: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == 3'd0) begin
                            r_bit_idx <= 3'd1;
                        end else begin
                            r_state <= c_ST_EOP_J;
                            r_dp    <= 1'b1;
                            r_dm    <= 1'b0;
                        end
                    end
                end
                c_ST_EOP_J: begin
                    if (w_bit_end) begin
                        r_state <= c_ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    if (w_bit_end) begin
                        if (w_stuff) begin
                            // Stuffed 0: toggle the line, hold the field position.
                            r_dp   <= r_dm;
                            r_dm   <= r_dp;
                            r_ones <= 3'd0;
                        end else begin
                            r_state   <= w_nstate;
                            r_shift   <= w_nshift[7:1];
                            r_bit_idx <= w_nidx;
                            r_pop     <= w_npop;
`ifdef USB_TX_CRC16_EN
                            r_crc_hi  <= w_ncrc_hi;
`endif
                            if (w_npop) begin
                                r_byte_cnt <= r_byte_cnt + 1'b1;
`ifdef USB_TX_CRC16_EN
                                r_crc      <= f_crc16_byte(r_crc, r_data);
`endif
                            end
                            if (w_nstate == c_ST_EOP_SE0) begin
                                r_dp      <= 1'b0;
                                r_dm      <= 1'b0;
                                r_bit_idx <= 3'd0;
                            end else begin
                                if (!w_nbit) begin
                                    r_dp <= r_dm;
                                    r_dm <= r_dp;
                                end
                                r_ones <= (w_nbit && w_nstate != c_ST_SYNC) ?
                                          r_ones + 3'd1 : 3'd0;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign r_enable = r_pop;
    assign tx_busy  = r_busy;
    assign tx_done  = r_done;
    assign d_plus   = r_dp;
    assign d_minus  = r_dm;

endmodule
`default_nettype wire

// File: tb/tb_usb_tx_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_tx_encoder
// Purpose  : Self-checking bench for usb_tx_encoder. A reference model turns
//            each requested packet into a per-clock list of expected
//            {d_plus, d_minus, r_enable, tx_busy, tx_done} values; a monitor
//            compares every clock against it. A FIFO model feeds payload.
// Options  : honours USB_TX_CRC16_EN the same way as the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_tx_encoder;

    localparam int CPB  = 4;
    localparam int MAXB = 64;
    localparam logic [4:0] c_IDLE_EXP = 5'b10000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_start = 1'b0;
    logic [3:0] tx_pid = 4'h0;
    logic [7:0] r_data = 8'h00;
    logic       empty = 1'b1;
    logic       r_enable;
    logic       tx_busy;
    logic       tx_done;
    logic       d_plus;
    logic       d_minus;

    always #5 clk = ~clk;

    usb_tx_encoder #(
        .CLKS_PER_BIT (CPB),
        .MAX_BYTES    (MAXB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_start (tx_start),
        .tx_pid   (tx_pid),
        .r_data   (r_data),
        .empty    (empty),
        .r_enable (r_enable),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .d_plus   (d_plus),
        .d_minus  (d_minus)
    );

    logic [7:0] fifo[$];
    logic [4:0] sb[$];
    int  n_pass = 0;
    int  n_fail = 0;
    int  n_total = 0;
    int  cyc = 0;
    int  rise_cyc = -1;
    int  done_cyc = -1;
    int  pops = 0;
    bit  mon_on = 1'b0;
    logic prev_busy = 1'b0;
    logic m_dp;
    logic m_dm;
    int  m_ones;

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Per-clock monitor and FIFO model (pop while r_enable is high).
    always @(negedge clk) begin : mon
        logic [4:0] obs;
        logic [4:0] exp;
        cyc++;
        if (mon_on) begin
            obs = {d_plus, d_minus, r_enable, tx_busy, tx_done};
            exp = (sb.size() > 0) ? sb.pop_front() : c_IDLE_EXP;
            n_total++;
            assert (obs === exp) n_pass++;
            else begin
                n_fail++;
                $error("FAIL line cyc %0d: got %b expected %b", cyc, obs, exp);
            end
            if (tx_busy === 1'b1 && prev_busy === 1'b0) rise_cyc = cyc;
            if (tx_done === 1'b1) done_cyc = cyc;
            prev_busy = tx_busy;
        end
        if (r_enable === 1'b1 && fifo.size() > 0) begin
            void'(fifo.pop_front());
            pops++;
        end
        empty  = (fifo.size() == 0);
        r_data = empty ? 8'h00 : fifo[0];
    end

`ifdef USB_TX_CRC16_EN
    function automatic logic [15:0] crc_upd(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] != d[i]) c = (c >> 1) ^ 16'hA001;
            else              c = c >> 1;
        end
        return c;
    endfunction
`endif

    task automatic push_bit(input logic pop);
        for (int i = 0; i < CPB; i++)
            sb.push_back({m_dp, m_dm, (i == 0) ? pop : 1'b0, 1'b1, 1'b0});
    endtask

    task automatic send_bit(input logic b, input bit counted, input logic pop);
        logic t;
        if (!b) begin t = m_dp; m_dp = m_dm; m_dm = t; end
        push_bit(pop);
        if (counted) begin
            m_ones = b ? m_ones + 1 : 0;
            if (m_ones == 6) begin
                t = m_dp; m_dp = m_dm; m_dm = t;
                push_bit(1'b0);
                m_ones = 0;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] v, input bit counted, input logic pop);
        for (int i = 0; i < 8; i++) send_bit(v[i], counted, pop && (i == 0));
    endtask

    task automatic build_pkt(input logic [3:0] pid);
        int n;
        logic [15:0] crc;
        sb.push_back(c_IDLE_EXP);       // clock on which tx_start is pending
        m_dp = 1'b1; m_dm = 1'b0; m_ones = 0;
        send_byte(8'h80, 1'b0, 1'b0);
        send_byte({~pid, pid}, 1'b1, 1'b0);
        if (pid[1:0] == 2'b11) begin
            n   = (fifo.size() < MAXB) ? fifo.size() : MAXB;
            crc = 16'hFFFF;
            for (int k = 0; k < n; k++) begin
                send_byte(fifo[k], 1'b1, 1'b1);
`ifdef USB_TX_CRC16_EN
                crc = crc_upd(crc, fifo[k]);
`endif
            end
`ifdef USB_TX_CRC16_EN
            send_byte(~crc[7:0], 1'b1, 1'b0);
            send_byte(~crc[15:8], 1'b1, 1'b0);
`endif
        end
        for (int i = 0; i < 2 * CPB; i++) sb.push_back(5'b00010);
        for (int i = 0; i < CPB; i++)     sb.push_back(5'b10010);
        sb.push_back(5'b10001);
    endtask

    task automatic start_pkt(input logic [3:0] pid);
        @(posedge clk); #1;
        build_pkt(pid);
        tx_pid   = pid;
        tx_start = 1'b1;
        @(posedge clk); #1;
        tx_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 6000 && sb.size() > 0; i++) @(posedge clk);
        #1;
        chk(tag, sb.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int p0;
        // Reset: monitor checks idle J, no strobes, while reset is held.
        repeat (2) @(posedge clk);
        #1 mon_on = 1'b1;
        @(posedge clk); #1;
        chk("reset_dplus", d_plus, 1);
        chk("reset_busy", tx_busy, 0);
        rst = 1'b0;
        repeat (3) @(posedge clk);

        // ACK: handshake only, fixed 19-bit length.
        pops = 0;
        start_pkt(4'h2);
        wait_done("ack_drain");
        chk("ack_latency", done_cyc - rise_cyc, 19 * CPB);
        chk("ack_pops", pops, 0);

        // DATA0 with 0xFF: stuff bit spans PID/payload boundary.
        fifo.push_back(8'hFF);
        pops = 0;
        start_pkt(4'h3);
        wait_done("ff_drain");
        chk("ff_pops", pops, 1);
        chk("ff_fifo_left", fifo.size(), 0);

        // DATA1 zero-length.
        pops = 0;
        start_pkt(4'hB);
        wait_done("zlp_drain");
        chk("zlp_pops", pops, 0);

        // DATA0 with 70 bytes: only MAX_BYTES leave the FIFO.
        for (int i = 0; i < 70; i++) fifo.push_back(8'($urandom_range(0, 255)));
        pops = 0;
        start_pkt(4'h3);
        wait_done("max_drain");
        chk("max_pops", pops, MAXB);
        chk("max_fifo_left", fifo.size(), 70 - MAXB);
        fifo.delete();
        @(negedge clk);

        // MDATA with stuff-heavy payload, tx_start pulsed mid-packet.
        fifo.push_back(8'h00); fifo.push_back(8'h7E); fifo.push_back(8'hFF);
        fifo.push_back(8'hFF); fifo.push_back(8'h3F);
        pops = 0;
        start_pkt(4'hF);
        repeat (100) @(posedge clk);
        #1;
        tx_pid = 4'h2; tx_start = 1'b1;
        @(posedge clk); #1;
        tx_start = 1'b0;
        wait_done("busy_start_drain");
        chk("busy_start_pops", pops, 5);

        // Reset in the middle of DATA.
        for (int i = 1; i <= 10; i++) fifo.push_back(8'(i));
        pops = 0;
        done_cyc = -1;
        start_pkt(4'h3);
        repeat (170) @(posedge clk);
        #1;
        chk("rst_mid_busy_before", tx_busy, 1);
        rst = 1'b1;
        while (sb.size() > 1) void'(sb.pop_back());
        @(posedge clk); #1;
        chk("rst_mid_dplus", d_plus, 1);
        chk("rst_mid_dminus", d_minus, 0);
        chk("rst_mid_busy", tx_busy, 0);
        rst = 1'b0;
        p0 = pops;
        repeat (100) @(posedge clk);
        #1;
        chk("rst_mid_no_pops", pops, p0);
        chk("rst_mid_no_done", done_cyc, -1);
        chk("rst_mid_fifo_kept", fifo.size(), 10 - p0);
        fifo.delete();
        @(negedge clk);

        // Normal packet after reset.
        start_pkt(4'h2);
        wait_done("post_rst_drain");
        chk("post_rst_latency", done_cyc - rise_cyc, 19 * CPB);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/usb_tx_encoder.md
# usb_tx_encoder

Transmit-side USB full-speed packet encoder, the outbound counterpart of the receiver's packet-order FIFO path. It drains payload bytes from an 8-bit show-ahead FIFO and builds the line packet: SYNC, PID, optional payload, optional CRC16, and EOP. The bit stream is bit-stuffed and NRZI-encoded onto the D+/D- pins. It sits between the transmit data FIFO and the USB pad drivers.

## Interface
- CLKS_PER_BIT, 4: system clocks per USB bit time (48 MHz clock → 12 Mb/s); ≥2
- MAX_BYTES, 64: maximum payload bytes per packet
- clk  in  1  system clock; all logic is rising-edge
- rst  in  1  reset, synchronous, active-high
- tx_start  in  1  one-clock request to send a packet; sampled only in IDLE
- tx_pid  in  4  PID code; captured with tx_start
- r_data  in  8  FIFO head byte; valid combinationally while empty=0
- empty  in  1  FIFO empty flag
- r_enable  out  1  one-clock pop strobe to the FIFO
- tx_busy  out  1  high while a packet is in flight
- tx_done  out  1  one-clock pulse after EOP completes
- d_plus  out  1  D+ line
- d_minus  out  1  D- line

## Operation
- Reset values: d_plus=1, d_minus=0 (idle J), r_enable=0, tx_busy=0, tx_done=0. The state machine goes to IDLE and the bit counters and stuff counter clear.
- States: IDLE → SYNC → PID → DATA → (CRC) → EOP_SE0 → EOP_J → IDLE.
- IDLE: on tx_start=1, capture tx_pid and go to SYNC. tx_start in any other state is ignored.
- SYNC: send byte 0x80 LSB first, giving line pattern KJKJKJKK.
- PID: send {~pid, pid} LSB first.
- PID class: if pid[1:0]=2'b11 (DATA0/DATA1/DATA2/MDATA), go to DATA. Otherwise go straight to EOP_SE0.
- DATA: at each byte boundary, if empty=0 and fewer than MAX_BYTES bytes have been sent, load r_data into the shift register and assert r_enable for that single clock. Otherwise leave DATA.
- Empty FIFO at DATA entry gives a zero-length packet.
- Bytes still in the FIFO beyond MAX_BYTES stay in the FIFO.
- Serialization: LSB first.
- Bit stuffing: after six consecutive 1 bits, insert one 0 bit. The run counter spans byte and field boundaries and covers PID, DATA and CRC bits. It clears at SYNC start and after every 0 bit, stuffed or real. A stuff bit owed after the final data or CRC bit is sent before EOP.
- NRZI: a 0 bit toggles the J/K line state; a 1 bit holds it. J is (1,0) and K is (0,1).
- EOP_SE0: drive (0,0) for 2 bit times. EOP_J: drive J for 1 bit time.
- After EOP_J: tx_done pulses and the state returns to IDLE.

## Timing
- Line state for the first SYNC bit appears on the clock after the clock that samples tx_start.
- Every line state, including stuff bits, holds exactly CLKS_PER_BIT clocks.
- tx_busy rises with the first SYNC bit and falls on the clock tx_done pulses.
- tx_done is high for one clock, the clock after the last EOP_J clock.
- r_enable pulses on the first clock of each payload byte's bit 0. There is at most one pop per byte and never a pop while empty=1.
- The next tx_start is accepted on the clock after tx_done.
- Reset mid-packet: on the next clock the lines go to J, tx_busy=0, no further pops occur, and there is no tx_done. A partially sent byte is not re-queued.

## Configuration
- USB_TX_CRC16_EN defined:
  - Data-class packets append CRC16 after the payload: polynomial 0x8005, init 0xFFFF, computed over payload bits only.
  - The CRC is sent inverted, LSB first, and is bit-stuffed.
  - A zero-length packet sends 0x00,0x00.
- USB_TX_CRC16_EN undefined:
  - No CRC state or logic; DATA goes directly to EOP_SE0.
  - Non-data PIDs behave identically either way.

## Test plan
- ACK, tx_pid=4'h2, CLKS_PER_BIT=4 -> SYNC then PID byte 0xD2, no stuff bits, no r_enable; EOP is SE0 for 8 clocks then J for 4 clocks; tx_done pulses exactly 76 clocks after the first SYNC clock.
- DATA0 (4'h3), FIFO holds 0xFF -> PID 0xC3 ends in two 1s; a stuffed 0 follows bit 3 of 0xFF; exactly one r_enable pulse; the FIFO ends empty.
- DATA1 (4'hB), empty FIFO, CRC enabled -> PID 0x4B, then CRC 0x00,0x00, then EOP; no r_enable.
- DATA0, FIFO holds 70 bytes, MAX_BYTES=64 -> exactly 64 r_enable pulses; 6 bytes remain; CRC (if enabled) covers 64 bytes only.
- rst asserted mid-DATA -> next clock d_plus=1, d_minus=0, tx_busy=0; no tx_done; a following tx_start sends a normal SYNC.
- tx_start pulsed while tx_busy=1 -> ignored; the packet in flight is unchanged.
